if_fetch_unit: RTL
==================

IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 SHALL provide port clk  input  1  single system clock; all state updates on rising edge.
REQ-002 SHALL provide port rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL provide port PC_update  input  16  branch/call/ret target computed by EX.
REQ-004 SHALL provide port PC_src  input  1  1 = take PC_update; 0 = sequential fetch.
REQ-005 SHALL provide port PC_update_done  input  1  EX update strobe; PC_src/PC_update are sampled only while this is high.
REQ-006 SHALL provide port stall  input  1  hazard stall; IF/ID outputs hold.
REQ-007 SHALL provide port imem_req  output  1  instruction memory request.
REQ-008 SHALL provide port imem_addr  output  16  word address of request.
REQ-009 SHALL provide port imem_ready  input  1  memory data valid, one-cycle pulse per request.
REQ-010 SHALL provide port imem_rdata  input  16  instruction word, valid when imem_ready.
REQ-011 SHALL provide port instr_out  output  16  IF/ID instruction register.
REQ-012 SHALL provide port PC_out  output  16  IF/ID PC+1 of instr_out (call return address).
REQ-013 SHALL provide port valid_out  output  1  instr_out holds a live instruction.
REQ-014 SHALL provide port flush  output  1  one-cycle squash pulse to downstream stages.

Function
REQ-015 SHALL hold a 16-bit PC register and a 1-entry skid buffer (data, PC+1, valid).
REQ-016 SHALL implement states FETCH, HOLD, DRAIN.
REQ-017 FETCH: imem_req=1, imem_addr=PC; imem_addr SHALL stay stable while imem_req=1 and imem_ready=0.
REQ-018 FETCH, imem_ready=1, stall=0, no redirect: next edge instr_out<=imem_rdata, PC_out<=PC+1, valid_out<=1, PC<=PC+1, stay FETCH (back-to-back requests allowed).
REQ-019 FETCH, imem_ready=1, stall=1: capture data and PC+1 into skid buffer, PC<=PC+1, go HOLD; IF/ID outputs unchanged.
REQ-020 HOLD: imem_req=0; while stall=1 hold everything; on stall=0 move skid buffer to IF/ID outputs (valid_out=1), clear buffer, go FETCH.
REQ-021 FETCH, imem_ready=0: IF/ID outputs hold if stall=1; if stall=0 valid_out<=0 (bubble).
REQ-022 Redirect = PC_update_done=1 and PC_src=1; PC_update_done=1 with PC_src=0 SHALL have no effect.
REQ-023 On redirect: PC<=PC_update, valid_out<=0, skid buffer cleared, flush=1 for exactly the following cycle; redirect SHALL override stall.
REQ-024 Redirect while request outstanding and imem_ready=0: go DRAIN; imem_req stays 1 at old address until imem_ready; returned data discarded; then FETCH at new PC.
REQ-025 Redirect in same cycle as imem_ready: data discarded; FETCH at PC_update next cycle.
REQ-026 Second redirect during DRAIN: PC SHALL take newest PC_update; flush pulses again.
REQ-027 PC and PC_out arithmetic SHALL be modulo 2^16 (0xFFFF+1 = 0x0000).
REQ-028 Redirect in HOLD: discard buffer, go FETCH at PC_update.

Reset
REQ-029 On rst=1, immediately and asynchronously: PC=0x0000, state FETCH, skid buffer invalid, instr_out=0x0000, PC_out=0x0000, valid_out=0, flush=0, imem_req=0, imem_addr=0x0000.
REQ-030 imem_req SHALL assert with imem_addr=0x0000 in the first cycle after rst deasserts.
REQ-031 Reset mid-handshake SHALL abandon the outstanding request; a later stray imem_ready SHALL be ignored until imem_req is reasserted.

Verification
REQ-032 Reset release, memory ready every cycle with rdata=addr^0xA5A5 -> instr_out sequence 0xA5A5,0xA5A4,..., PC_out 1,2,3, valid_out=1 continuous.
REQ-033 stall=1 for 3 cycles when ready arrives at PC=0x0004 -> instr at 0x0003 held, req low in HOLD, on release instr 0x0004 appears with PC_out 0x0005, no instruction lost or duplicated.
REQ-034 Redirect to 0x0100 with 2-cycle-latency request outstanding at 0x0007 -> flush one cycle, req held at 0x0007 until ready, data discarded, next req addr 0x0100.
REQ-035 Redirect to 0x0200 with PC_src=0 pulse interleaved, plus stall=1 during redirect -> PC_src=0 ignored, redirect taken despite stall, valid_out=0.
REQ-036 PC=0xFFFF fetched -> PC_out=0x0000, next imem_addr=0x0000.
REQ-037 rst asserted while imem_req=1 awaiting ready -> all outputs reset same cycle; ready arriving during reset ignored; fetch restarts at 0x0000.

Source files
------------

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: PC register, request/handshake FSM, one-entry skid
// buffer and IF/ID output register, with redirect/flush handling.
module if_fetch_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] PC_update,
    input  logic        PC_src,
    input  logic        PC_update_done,
    input  logic        stall,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ready,
    input  logic [15:0] imem_rdata,
    output logic [15:0] instr_out,
    output logic [15:0] PC_out,
    output logic        valid_out,
    output logic        flush
);

    typedef enum logic [1:0] {FETCH, HOLD, DRAIN} state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] drain_addr_q, drain_addr_d;
    logic [15:0] skid_data_q, skid_data_d;
    logic [15:0] skid_pc_q, skid_pc_d;
    logic        skid_valid_q, skid_valid_d;
    logic [15:0] instr_q, instr_d;
    logic [15:0] pc_out_q, pc_out_d;
    logic        valid_q, valid_d;
    logic        flush_q, flush_d;

    logic        redirect;
    logic [15:0] pc_inc;

    assign redirect = PC_update_done & PC_src;
    assign pc_inc   = pc_q + 16'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= FETCH;
            pc_q         <= 16'h0000;
            drain_addr_q <= 16'h0000;
            skid_data_q  <= 16'h0000;
            skid_pc_q    <= 16'h0000;
            skid_valid_q <= 1'b0;
            instr_q      <= 16'h0000;
            pc_out_q     <= 16'h0000;
            valid_q      <= 1'b0;
            flush_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drain_addr_q <= drain_addr_d;
            skid_data_q  <= skid_data_d;
            skid_pc_q    <= skid_pc_d;
            skid_valid_q <= skid_valid_d;
            instr_q      <= instr_d;
            pc_out_q     <= pc_out_d;
            valid_q      <= valid_d;
            flush_q      <= flush_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drain_addr_d = drain_addr_q;
        skid_data_d  = skid_data_q;
        skid_pc_d    = skid_pc_q;
        skid_valid_d = skid_valid_q;
        instr_d      = instr_q;
        pc_out_d     = pc_out_q;
        valid_d      = valid_q;
        flush_d      = 1'b0;

        case (state_q)
            FETCH: begin
                if (redirect) begin
                    pc_d         = PC_update;
                    valid_d      = 1'b0;
                    skid_valid_d = 1'b0;
                    flush_d      = 1'b1;
                    // An unanswered request must still be completed at its old address.
                    if (!imem_ready) begin
                        state_d      = DRAIN;
                        drain_addr_d = pc_q;
                    end
                end else if (imem_ready) begin
                    pc_d = pc_inc;
                    if (!stall) begin
                        instr_d  = imem_rdata;
                        pc_out_d = pc_inc;
                        valid_d  = 1'b1;
                    end else begin
                        skid_data_d  = imem_rdata;
                        skid_pc_d    = pc_inc;
                        skid_valid_d = 1'b1;
                        state_d      = HOLD;
                    end
                end else if (!stall) begin
                    valid_d = 1'b0;
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_d         = PC_update;
                    valid_d      = 1'b0;
                    skid_valid_d = 1'b0;
                    flush_d      = 1'b1;
                    state_d      = FETCH;
                end else if (!stall) begin
                    instr_d      = skid_data_q;
                    pc_out_d     = skid_pc_q;
                    valid_d      = skid_valid_q;
                    skid_valid_d = 1'b0;
                    state_d      = FETCH;
                end
            end
            DRAIN: begin
                if (redirect) begin
                    pc_d    = PC_update;
                    flush_d = 1'b1;
                end
                if (imem_ready) begin
                    state_d = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    // Request is forced low for the whole time reset is asserted.
    assign imem_req  = ~rst & (state_q != HOLD);
    assign imem_addr = (state_q == DRAIN) ? drain_addr_q : pc_q;
    assign instr_out = instr_q;
    assign PC_out    = pc_out_q;
    assign valid_out = valid_q;
    assign flush     = flush_q;

endmodule
